// File: rtl/cnu_msg_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cnu_msg_gen
//  Purpose  : Check-node message expander for the offset-min-sum LDPC decoder.
//             Takes one compressed check-node record (min, min2, min_idx,
//             per-edge signs) and streams D check-to-variable messages,
//             edge 0..D-1, on a valid/ready interface.
//  Revision : 1.0  initial release
// ============================================================================
module cnu_msg_gen #(
  parameter int data_w = 8,
  parameter int idx_w  = 8,
  parameter int D      = 5,
  parameter int OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] min,
  input  logic [data_w-1:0] min2,
  input  logic [idx_w-1:0]  min_idx,
  input  logic [D-1:0]      sign_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w-1:0] out_mag,
  output logic              out_sign,
  output logic [idx_w-1:0]  out_idx,
  output logic              out_last
);

  localparam logic [idx_w-1:0]  c_last_idx = idx_w'(D - 1);
  localparam logic [data_w-1:0] c_offset   = data_w'(OFFSET);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Stored record for the beats after beat 0
  logic [data_w-1:0] r_min;
  logic [data_w-1:0] r_min2;
  logic [idx_w-1:0]  r_min_idx;
  logic [D-1:0]      r_sign;
  logic              r_parity;

  logic              w_fire;
  logic              w_last_fire;
  logic              w_accept;
  logic [idx_w-1:0]  w_next_idx;

  // Magnitude of beat k: the edge that owns the minimum gets min2, all
  // others get min. A padding min_idx (>= D) never matches k (< D), so
  // every beat then carries min. Offset subtraction saturates at zero.
  function automatic logic [data_w-1:0] f_mag(
    input logic [data_w-1:0] mn,
    input logic [data_w-1:0] mn2,
    input logic [idx_w-1:0]  mi,
    input logic [idx_w-1:0]  k
  );
    logic [data_w-1:0] raw;
    raw = (mi == k) ? mn2 : mn;
    return (raw > c_offset) ? (raw - c_offset) : '0;
  endfunction

  // Extrinsic sign of beat k: total parity with edge k's own sign removed
  function automatic logic f_sign(
    input logic [D-1:0]     s,
    input logic             p,
    input logic [idx_w-1:0] k
  );
    logic b;
    b = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (k == idx_w'(i)) b = s[i];
    end
    return p ^ b;
  endfunction

  assign w_fire      = out_valid & out_ready;
  assign w_last_fire = w_fire & out_last;
  assign in_ready    = (r_state == S_IDLE) | w_last_fire;
  assign w_accept    = in_valid & in_ready;
  assign w_next_idx  = out_idx + idx_w'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: stay in EMIT across back-to-back records
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_EMIT;
      S_EMIT: if (w_last_fire) w_state_nxt = in_valid ? S_EMIT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Record capture and registered beat generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min     <= '0;
      r_min2    <= '0;
      r_min_idx <= '0;
      r_sign    <= '0;
      r_parity  <= 1'b0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_sign  <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (w_accept) begin
      // Beat 0 is built straight from the accepted record; the retiring
      // beat (if any) has already been consumed on this edge.
      r_min     <= min;
      r_min2    <= min2;
      r_min_idx <= min_idx;
      r_sign    <= sign_in;
      r_parity  <= ^sign_in;
      out_valid <= 1'b1;
      out_mag   <= f_mag(min, min2, min_idx, '0);
      out_sign  <= (^sign_in) ^ sign_in[0];
      out_idx   <= '0;
      out_last  <= (c_last_idx == '0);
    end else if (w_last_fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (w_fire) begin
      out_mag   <= f_mag(r_min, r_min2, r_min_idx, w_next_idx);
      out_sign  <= f_sign(r_sign, r_parity, w_next_idx);
      out_idx   <= w_next_idx;
      out_last  <= (w_next_idx == c_last_idx);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnu_msg_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnu_msg_gen
//  Purpose  : Scoreboard bench for cnu_msg_gen; two instances (OFFSET 0 and
//             OFFSET 1) share one stimulus stream and have separate queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cnu_msg_gen;

  localparam int D  = 5;
  localparam int DW = 8;
  localparam int IW = 8;

  typedef struct packed {
    logic [DW-1:0] mag;
    logic          sign;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] mn;
    logic [DW-1:0] mn2;
    logic [IW-1:0] mi;
    logic [D-1:0]  s;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] min = '0;
  logic [DW-1:0] min2 = '0;
  logic [IW-1:0] min_idx = '0;
  logic [D-1:0]  sign_in = '0;
  logic          out_ready = 1'b0;

  logic          in_ready0, out_valid0, out_sign0, out_last0;
  logic [DW-1:0] out_mag0;
  logic [IW-1:0] out_idx0;
  logic          in_ready1, out_valid1, out_sign1, out_last1;
  logic [DW-1:0] out_mag1;
  logic [IW-1:0] out_idx1;

  int    checks = 0;
  int    errors = 0;
  beat_t q0[$];
  beat_t q1[$];
  bit    rand_ready = 1'b0;
  bit    ready_force = 1'b0;

  cnu_msg_gen #(.data_w(DW), .idx_w(IW), .D(D), .OFFSET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .min(min), .min2(min2), .min_idx(min_idx), .sign_in(sign_in),
    .out_valid(out_valid0), .out_ready(out_ready), .out_mag(out_mag0),
    .out_sign(out_sign0), .out_idx(out_idx0), .out_last(out_last0)
  );

  cnu_msg_gen #(.data_w(DW), .idx_w(IW), .D(D), .OFFSET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .min(min), .min2(min2), .min_idx(min_idx), .sign_in(sign_in),
    .out_valid(out_valid1), .out_ready(out_ready), .out_mag(out_mag1),
    .out_sign(out_sign1), .out_idx(out_idx1), .out_last(out_last1)
  );

  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #300000;
    $display("FAIL watchdog expired: actual still running, required finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: message k of a record, from the min-sum rules
  function automatic beat_t model(input rec_t r, input int k, input int off);
    beat_t b;
    int    raw, mag, ones;
    raw  = (int'(r.mi) == k) ? int'(r.mn2) : int'(r.mn);
    mag  = raw - off;
    if (mag < 0) mag = 0;
    ones = 0;
    for (int i = 0; i < D; i++) ones += int'(r.s[i]);
    b.mag  = DW'(mag);
    b.sign = ((ones % 2) == 1) ^ r.s[k];
    b.idx  = IW'(k);
    b.last = (k == D - 1);
    return b;
  endfunction

  function automatic void push_rec(input rec_t r);
    for (int k = 0; k < D; k++) begin
      q0.push_back(model(r, k, 0));
      q1.push_back(model(r, k, 1));
    end
  endfunction

  // Compare one presented beat; pop on handshake, peek while stalled
  task automatic mon_one(input int which, input logic v, input logic r,
                         input logic [DW-1:0] mag, input logic s,
                         input logic [IW-1:0] idx, input logic last);
    beat_t e;
    int    sz;
    if (!v) return;
    sz = (which == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected beat: actual idx %0d, required none", which, idx);
      return;
    end
    if (which == 0) begin
      e = q0[0];
      if (r) void'(q0.pop_front());
    end else begin
      e = q1[0];
      if (r) void'(q1.pop_front());
    end
    chk($sformatf("dut%0d out_mag", which), int'(mag), int'(e.mag));
    chk($sformatf("dut%0d out_sign", which), int'(s), int'(e.sign));
    chk($sformatf("dut%0d out_idx", which), int'(idx), int'(e.idx));
    chk($sformatf("dut%0d out_last", which), int'(last), int'(e.last));
  endtask

  // Monitor: samples mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      mon_one(0, out_valid0, out_ready, out_mag0, out_sign0, out_idx0, out_last0);
      mon_one(1, out_valid1, out_ready, out_mag1, out_sign1, out_idx1, out_last1);
    end
  end

  // Downstream ready driver
  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Offer one record; expectations pushed when it is accepted
  task automatic send(input logic [DW-1:0] mn, input logic [DW-1:0] mn2,
                      input logic [IW-1:0] mi, input logic [D-1:0] s);
    rec_t r;
    int   t;
    r.mn = mn; r.mn2 = mn2; r.mi = mi; r.s = s;
    min = mn; min2 = mn2; min_idx = mi; sign_in = s;
    in_valid = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready0) break;
    end
    if (t == 200) begin
      checks++;
      errors++;
      $display("FAIL send timeout: actual in_ready 0, required 1");
      in_valid = 1'b0;
      return;
    end
    push_rec(r);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !out_valid0) break;
    end
    if (t == 400) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: actual %0d beats pending, required 0", q0.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rec_t rb;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst out_valid", int'(out_valid0), 0);
    chk("rst out_valid dut1", int'(out_valid1), 0);
    chk("rst in_ready", int'(in_ready0), 1);
    chk("rst out_mag", int'(out_mag0), 0);
    chk("rst out_idx", int'(out_idx0), 0);
    chk("rst out_sign", int'(out_sign0), 0);
    chk("rst out_last", int'(out_last0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ready_force = 1'b1;

    // T1 basic record
    send(8'd3, 8'd7, 8'd2, 5'b00101);
    wait_idle();

    // T2 stall while beat 2 is shown
    send(8'd3, 8'd7, 8'd2, 5'b00101);
    @(posedge clk);
    @(posedge clk); #1;
    ready_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2 hold out_valid", int'(out_valid0), 1);
      chk("t2 hold out_mag", int'(out_mag0), 7);
      chk("t2 hold out_idx", int'(out_idx0), 2);
      chk("t2 hold out_sign", int'(out_sign0), 1);
    end
    @(posedge clk); #1;
    ready_force = 1'b1;
    wait_idle();

    // T3 back-to-back records, in_valid held
    send(8'd5, 8'd6, 8'd0, 5'b01100);
    rb.mn = 8'd10; rb.mn2 = 8'd20; rb.mi = 8'd4; rb.s = 5'b10110;
    min = rb.mn; min2 = rb.mn2; min_idx = rb.mi; sign_in = rb.s;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("t3 out_valid c%0d", c), int'(out_valid0), 1);
      chk($sformatf("t3 in_ready c%0d", c), int'(in_ready0), (c == 4 || c == 9) ? 1 : 0);
      if (c == 4) push_rec(rb);
      @(posedge clk); #1;
      if (c == 4) in_valid = 1'b0;
    end
    @(negedge clk);
    chk("t3 idle out_valid", int'(out_valid0), 0);
    @(posedge clk); #1;

    // T4 saturation at zero (dut1 has OFFSET 1)
    send(8'd0, 8'd1, 8'd0, 5'b00000);
    wait_idle();

    // T5 padding min_idx, all signs negative
    send(8'd4, 8'd9, 8'd5, 5'b11111);
    wait_idle();

    // T6 asynchronous reset during beat 2
    send(8'd20, 8'd30, 8'd1, 5'b01001);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async out_valid", int'(out_valid0), 0);
    chk("t6 async out_valid dut1", int'(out_valid1), 0);
    chk("t6 async out_idx", int'(out_idx0), 0);
    chk("t6 async in_ready", int'(in_ready0), 1);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6 post in_ready", int'(in_ready0), 1);
    chk("t6 post out_valid", int'(out_valid0), 0);
    @(posedge clk); #1;
    send(8'd50, 8'd60, 8'd3, 5'b00011);
    wait_idle();

    // Randomized records with random downstream backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] a, b;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      a = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 2)) : DW'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 2)) : DW'($urandom_range(0, 255));
      send(a, b, IW'($urandom_range(0, 7)), D'($urandom_range(0, 31)));
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
